// File: rtl/memory_bank_if.sv
// Access bus for memory_bank: read/write ports, re-initialisation request and status.
interface memory_bank_if #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             clear;
  logic             ren;
  logic             wen;
  logic [AW-1:0]    wrAddr;
  logic [AW-1:0]    rdAddr;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             rdValid;
  logic             busy;

  modport master (
    output clear, ren, wen, wrAddr, rdAddr, dataIn,
    input  dataOut, rdValid, busy
  );

  modport slave (
    input  clear, ren, wen, wrAddr, rdAddr, dataIn,
    output dataOut, rdValid, busy
  );
endinterface

// File: rtl/memory_bank.sv
// Register-file memory with mem[i] = i init sequencer and registered read port.
// Optional MEMORY_BYPASS_EN selects write-first collisions; default is read-first.
module memory_bank #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clock,
  input  logic          resetN,
  memory_bank_if.slave  bus
);
  localparam int unsigned  AW        = $clog2(DEPTH);
  localparam logic [AW:0]  DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_next;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             rd_fire;
  logic [WIDTH-1:0] rd_data;
  logic             wr_in_range;
  logic             rd_in_range;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             busy;

  assign wr_in_range = {1'b0, bus.wrAddr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, bus.rdAddr} < DEPTH_EXT;

  // State and init pointer
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next state, array write port and read acceptance
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    mem_we     = 1'b0;
    mem_waddr  = ptr;
    mem_wdata  = WIDTH'(ptr);
    rd_fire    = 1'b0;
    case (state)
      INIT: begin
        mem_we = 1'b1;
        if (ptr == LAST_PTR) begin
          state_next = READY;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + AW'(1);
        end
      end
      READY: begin
        if (bus.clear) begin
          state_next = INIT;
          ptr_next   = '0;
        end else begin
          rd_fire = bus.ren;
          if (bus.wen && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = bus.wrAddr;
            mem_wdata = bus.dataIn;
          end
        end
      end
      default: begin
        state_next = INIT;
        ptr_next   = '0;
      end
    endcase
    // Reset edge must not disturb the array or launch a read
    if (!resetN) begin
      mem_we  = 1'b0;
      rd_fire = 1'b0;
    end
  end

  // Read data selection; out-of-range addresses return zero
  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = mem[bus.rdAddr];
`ifdef MEMORY_BYPASS_EN
      if (state == READY && mem_we && mem_waddr == bus.rdAddr) begin
        rd_data = mem_wdata;
      end
`endif
    end
  end

  // Storage is never reset; INIT overwrites it
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b1;
    end else begin
      rd_valid <= rd_fire;
      busy     <= (state_next == INIT);
      if (rd_fire) begin
        data_out <= rd_data;
      end
    end
  end

  assign bus.dataOut = data_out;
  assign bus.rdValid = rd_valid;
  assign bus.busy    = busy;
endmodule

// File: tb/tb_memory_bank.sv
// Scoreboard bench for memory_bank: an 8x15 instance and a 6x4 non-power-of-two instance.
module tb_memory_bank;
  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  memory_bank_if #(.WIDTH(15), .DEPTH(8)) mb ();
  memory_bank_if #(.WIDTH(4),  .DEPTH(6)) sb ();

  memory_bank #(.WIDTH(15), .DEPTH(8)) dut   (.clock(clock), .resetN(resetN), .bus(mb));
  memory_bank #(.WIDTH(4),  .DEPTH(6)) dut_s (.clock(clock), .resetN(resetN), .bus(sb));

  typedef struct {
    logic [14:0] data;
    int          due;
  } exp_t;

  exp_t mq[$];
  exp_t sq[$];
  exp_t me;
  exp_t se;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   mc;
  int   sc;

`ifdef MEMORY_BYPASS_EN
  localparam logic [14:0] COLL_EXP = 15'h1234;
`else
  localparam logic [14:0] COLL_EXP = 15'h0005;
`endif

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop expected read results whenever rdValid is presented
  always @(negedge clock) begin
    if (mb.rdValid === 1'b1) begin
      if (mq.size() == 0) begin
        check("m_unexpected_rdValid", 32'(mb.rdValid), 32'(0));
      end else begin
        me = mq.pop_front();
        check("m_rdData", 32'(mb.dataOut), 32'(me.data));
        check("m_rdLatency", 32'(cyc), 32'(me.due));
      end
    end else if (mq.size() != 0 && mq[0].due <= cyc) begin
      check("m_missing_rdValid", 32'(mb.rdValid), 32'(1));
      void'(mq.pop_front());
    end
    if (sb.rdValid === 1'b1) begin
      if (sq.size() == 0) begin
        check("s_unexpected_rdValid", 32'(sb.rdValid), 32'(0));
      end else begin
        se = sq.pop_front();
        check("s_rdData", 32'(sb.dataOut), 32'(se.data));
        check("s_rdLatency", 32'(cyc), 32'(se.due));
      end
    end else if (sq.size() != 0 && sq[0].due <= cyc) begin
      check("s_missing_rdValid", 32'(sb.rdValid), 32'(1));
      void'(sq.pop_front());
    end
  end

  task automatic m_idle();
    mb.clear = 1'b0;
    mb.ren   = 1'b0;
    mb.wen   = 1'b0;
  endtask

  task automatic s_idle();
    sb.clear = 1'b0;
    sb.ren   = 1'b0;
    sb.wen   = 1'b0;
  endtask

  task automatic m_rd(input logic [2:0] a, input logic [14:0] e);
    mb.ren    = 1'b1;
    mb.rdAddr = a;
    mq.push_back('{data: e, due: cyc + 1});
    @(negedge clock);
    mb.ren = 1'b0;
  endtask

  task automatic m_wr(input logic [2:0] a, input logic [14:0] d);
    mb.wen    = 1'b1;
    mb.wrAddr = a;
    mb.dataIn = d;
    @(negedge clock);
    mb.wen = 1'b0;
  endtask

  task automatic m_rdwr(input logic [2:0] a, input logic [14:0] d, input logic [14:0] e);
    mb.ren    = 1'b1;
    mb.wen    = 1'b1;
    mb.rdAddr = a;
    mb.wrAddr = a;
    mb.dataIn = d;
    mq.push_back('{data: e, due: cyc + 1});
    @(negedge clock);
    mb.ren = 1'b0;
    mb.wen = 1'b0;
  endtask

  task automatic s_rd(input logic [2:0] a, input logic [3:0] e);
    sb.ren    = 1'b1;
    sb.rdAddr = a;
    sq.push_back('{data: 15'(e), due: cyc + 1});
    @(negedge clock);
    sb.ren = 1'b0;
  endtask

  task automatic s_wr(input logic [2:0] a, input logic [3:0] d);
    sb.wen    = 1'b1;
    sb.wrAddr = a;
    sb.dataIn = d;
    @(negedge clock);
    sb.wen = 1'b0;
  endtask

  // Count negedges with busy high on each instance, bounded
  task automatic wait_ready(output int m_cnt, output int s_cnt);
    m_cnt = 0;
    s_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!mb.busy && !sb.busy) break;
      if (mb.busy) m_cnt++;
      if (sb.busy) s_cnt++;
      @(negedge clock);
    end
  endtask

  initial begin
    resetN    = 1'b0;
    m_idle();
    s_idle();
    mb.wrAddr = '0;
    mb.rdAddr = '0;
    mb.dataIn = '0;
    sb.wrAddr = '0;
    sb.rdAddr = '0;
    sb.dataIn = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);

    check("reset_dataOut", 32'(mb.dataOut), 32'(0));
    check("reset_rdValid", 32'(mb.rdValid), 32'(0));
    check("reset_busy", 32'(mb.busy), 32'(1));
    check("reset_s_busy", 32'(sb.busy), 32'(1));

    resetN = 1'b1;
    wait_ready(mc, sc);
    check("init_busy_cycles", 32'(mc), 32'(8));
    check("init_s_busy_cycles", 32'(sc), 32'(6));
    for (int i = 0; i < 8; i++) m_rd(3'(i), 15'(i));

    m_wr(3'd3, 15'h7ABC);
    m_rd(3'd3, 15'h7ABC);

    m_rdwr(3'd5, 15'h1234, COLL_EXP);
    m_rd(3'd5, 15'h1234);

    // Clear with a same-cycle write and read that must both be dropped
    m_wr(3'd0, 15'h7FFF);
    mb.clear  = 1'b1;
    mb.wen    = 1'b1;
    mb.wrAddr = 3'd1;
    mb.dataIn = 15'h2222;
    mb.ren    = 1'b1;
    mb.rdAddr = 3'd0;
    @(negedge clock);
    m_idle();
    wait_ready(mc, sc);
    check("clear_busy_cycles", 32'(mc), 32'(8));
    m_rd(3'd0, 15'd0);
    m_rd(3'd1, 15'd1);

    // Reset while the init pointer sits at 4
    m_wr(3'd6, 15'h0ABC);
    mb.clear = 1'b1;
    @(negedge clock);
    m_idle();
    repeat (4) @(negedge clock);
    resetN = 1'b0;
    @(negedge clock);
    check("midinit_reset_dataOut", 32'(mb.dataOut), 32'(0));
    check("midinit_reset_rdValid", 32'(mb.rdValid), 32'(0));
    check("midinit_reset_busy", 32'(mb.busy), 32'(1));
    resetN = 1'b1;
    wait_ready(mc, sc);
    check("midinit_busy_cycles", 32'(mc), 32'(8));
    check("midinit_s_busy_cycles", 32'(sc), 32'(6));
    for (int i = 0; i < 8; i++) m_rd(3'(i), 15'(i));

    // Non-power-of-two instance: address 7 is out of range
    s_wr(3'd7, 4'hF);
    s_rd(3'd7, 4'h0);
    s_rd(3'd5, 4'h5);
    s_wr(3'd2, 4'hA);
    s_rd(3'd2, 4'hA);
    s_rd(3'd3, 4'h3);

    repeat (3) @(negedge clock);
    check("m_queue_drained", 32'(mq.size()), 32'(0));
    check("s_queue_drained", 32'(sq.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
